// File: rtl/lsu_mem_port_pkg.sv
// Shared types and helpers for the LSU data-RAM port.
package lsu_pkg;

    // Controller states; exposed on the debug port of lsu_mem_port.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        WHOLD = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    // Access size codes as carried on req_size / mem_len.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Number of bytes touched by an access of the given size code (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Bundle of the core-facing request/response handshake and the RAM data port.
//
// Handshake rules (both req and resp channels):
//   - A transfer happens on a rising edge where valid and ready are both high.
//   - The sender keeps valid and its payload stable until that edge; valid is
//     never made conditional on ready.
//   - ready may change freely while valid is low.
// RAM port: mem_addr/mem_wdata/mem_len are stable whenever mem_we or mem_re is
// high; the RAM is level-sensitive and samples them throughout that window.
interface lsu_mem_port_if #(
    parameter int ALEN = 64,
    parameter int DLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [ALEN-1:0] req_addr;
    logic [DLEN-1:0] req_wdata;
    logic [1:0]      req_size;
    logic            req_unsigned;

    logic            resp_valid;
    logic            resp_ready;
    logic [DLEN-1:0] resp_rdata;
    logic            resp_err;

    logic [ALEN-1:0] mem_addr;
    logic [DLEN-1:0] mem_wdata;
    logic [1:0]      mem_len;
    logic            mem_we;
    logic            mem_re;
    logic [DLEN-1:0] mem_rdata;

    // The LSU port block itself.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_len, mem_we, mem_re
    );

    // The core execute stage together with the RAM.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_len, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_mem_port_load_extend.sv
// Extracts the low 1/2/4/8 bytes of the RAM read word and sign- or zero-extends.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int DLEN = 64
) (
    input  logic [DLEN-1:0] rdata_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [DLEN-1:0] ext_data_o
);

    logic fill_b;
    logic fill_h;
    logic fill_w;

    // Fill bit for the upper bytes: the source sign bit, or 0 for unsigned loads.
    always_comb begin
        fill_b = ~unsigned_i & rdata_i[7];
        fill_h = ~unsigned_i & rdata_i[15];
        fill_w = ~unsigned_i & rdata_i[31];
    end

    // Select the extended value for the access size; doublewords pass through.
    always_comb begin
        ext_data_o = rdata_i;
        case (size_i)
            SZ_B:    ext_data_o = {{(DLEN-8){fill_b}},  rdata_i[7:0]};
            SZ_H:    ext_data_o = {{(DLEN-16){fill_h}}, rdata_i[15:0]};
            SZ_W:    ext_data_o = {{(DLEN-32){fill_w}}, rdata_i[31:0]};
            default: ext_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Non-pipelined initiator for the byte-addressed data RAM: one request in
// flight, registered RAM controls, alignment/range screening before access.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ALEN        = 64,
    parameter int DLEN        = 64,
    parameter int MEM_SIZE    = 1024,
    parameter int CHECK_ALIGN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_port_if.slave bus,
    output lsu_state_t    dbg_state_o
);

    localparam int NLANES = DLEN / 8;
    // Exclusive upper bound of the RAM, widened so addr+bytes cannot wrap.
    localparam logic [ALEN:0] MEM_LIMIT = (ALEN+1)'(MEM_SIZE);

    lsu_state_t      state_q, state_d;

    logic            req_ready_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [DLEN-1:0] resp_rdata_q;
    logic [ALEN-1:0] mem_addr_q;
    logic [DLEN-1:0] mem_wdata_q;
    logic [1:0]      mem_len_q;
    logic            mem_we_q;
    logic            mem_re_q;
    logic            uns_q;

    logic            accept;
    logic            resp_done;
    logic [3:0]      nbytes;
    logic [3:0]      align_mask;
    logic            misalign;
    logic [ALEN:0]   end_addr;
    logic            out_of_range;
    logic            req_err;
    logic [DLEN-1:0] pack_wdata;
    logic [DLEN-1:0] ext_data;

    assign accept    = req_ready_q & bus.req_valid;
    assign resp_done = resp_valid_q & bus.resp_ready;

    // Screen the incoming request for misalignment and for running past the RAM end.
    always_comb begin
        nbytes       = size_bytes(bus.req_size);
        align_mask   = nbytes - 4'd1;
        misalign     = |(bus.req_addr[2:0] & align_mask[2:0]);
        end_addr     = {1'b0, bus.req_addr} + {{(ALEN-3){1'b0}}, nbytes};
        out_of_range = end_addr > MEM_LIMIT;
        req_err      = ((CHECK_ALIGN != 0) && misalign) || out_of_range;
    end

    // Byte k of the right-justified store data goes to lane k counted from the top; unused lanes are 0.
    always_comb begin
        pack_wdata = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (4'(k) < nbytes) begin
                pack_wdata[DLEN-1-8*k -: 8] = bus.req_wdata[8*k +: 8];
            end
        end
    end

    lsu_load_extend #(
        .DLEN (DLEN)
    ) u_load_extend (
        .rdata_i    (bus.mem_rdata),
        .size_i     (mem_len_q),
        .unsigned_i (uns_q),
        .ext_data_o (ext_data)
    );

    // Next-state logic: one access cycle for loads, access plus hold cycle for stores.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (bus.req_we) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = RESP;
            WRITE:   state_d = WHOLD;
            WHOLD:   state_d = RESP;
            RESP: begin
                if (resp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered handshake and RAM strobes, decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            req_ready_q  <= (state_d == IDLE);
            resp_valid_q <= (state_d == RESP);
            mem_we_q     <= (state_d == WRITE);
            mem_re_q     <= (state_d == READ);
        end
    end

    // Request latch on accept (keeps the RAM bus stable) and load-data capture at the end of READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_len_q    <= SZ_B;
            uns_q        <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else if (accept) begin
            mem_addr_q   <= bus.req_addr;
            mem_wdata_q  <= pack_wdata;
            mem_len_q    <= bus.req_size;
            uns_q        <= bus.req_unsigned;
            resp_err_q   <= req_err;
            resp_rdata_q <= '0;
        end else if (state_q == READ) begin
            resp_rdata_q <= ext_data;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_len    = mem_len_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port with a byte-array RAM and an expected-response queue.
module tb_lsu_mem_port;
    import lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_port_if #(.ALEN(64), .DLEN(64)) bus ();
    lsu_state_t dbg_state;

    lsu_mem_port #(
        .ALEN        (64),
        .DLEN        (64),
        .MEM_SIZE    (1024),
        .CHECK_ALIGN (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- RAM model ----------------
    logic [7:0] ram     [0:1023];
    logic [7:0] ref_mem [0:1023];

    always_comb begin
        logic [63:0] a;
        bus.mem_rdata = '0;
        a = '0;
        for (int k = 0; k < 8; k++) begin
            a = bus.mem_addr + 64'(k);
            if (a < 64'd1024) bus.mem_rdata[8*k +: 8] = ram[a[9:0]];
        end
    end

    always @(posedge clk) begin
        logic [63:0] a;
        if (bus.mem_we) begin
            for (int k = 0; k < 8; k++) begin
                a = bus.mem_addr + 64'(k);
                if ((k < (1 << bus.mem_len)) && (a < 64'd1024)) ram[a[9:0]] = bus.mem_wdata[63-8*k -: 8];
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [64:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic logic model_err(input logic [63:0] addr, input logic [1:0] s);
        return ((addr % 64'(nb(s))) != 0) || ((addr + 64'(nb(s))) > 64'd1024);
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [1:0] s, input logic uns);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < nb(s); k++) v[8*k +: 8] = ref_mem[addr[9:0] + 10'(k)];
        if (!uns && (s != SZ_D) && v[8*nb(s)-1]) begin
            for (int i = 8*nb(s); i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [63:0] pack_exp(input logic [63:0] wd, input logic [1:0] s);
        logic [63:0] p;
        p = '0;
        for (int k = 0; k < nb(s); k++) p[63-8*k -: 8] = wd[8*k +: 8];
        return p;
    endfunction

    // ---------------- driver tasks ----------------
    // Present one request, then watch the RAM port until resp_valid appears.
    task automatic send(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic uns,
                        input logic [63:0] exp_rdata, input logic exp_err, input string tag);
        int w, lat, we_c, re_c, both, exp_lat;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) check({tag, "_ready_timeout"}, 64'(bus.req_ready), 64'd1);
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_valid    = 1'b1;
        exp_q.push_back({exp_err, exp_rdata});
        if (we && !exp_err) begin
            for (int k = 0; k < nb(size); k++) ref_mem[addr[9:0] + 10'(k)] = wdata[8*k +: 8];
        end
        @(posedge clk);
        #1;
        // Junk on the request bus must be ignored while busy.
        bus.req_valid = $urandom_range(0, 1);
        bus.req_we    = $urandom_range(0, 1);
        bus.req_addr  = 64'($urandom_range(0, 1023));
        bus.req_wdata = {$urandom, $urandom};
        lat = 0; we_c = 0; re_c = 0; both = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                we_c++;
                check({tag, "_mem_wdata"}, bus.mem_wdata, pack_exp(wdata, size));
            end
            if (bus.mem_re) re_c++;
            if (bus.mem_we && bus.mem_re) both++;
            if ((bus.mem_we || bus.mem_re) && !exp_err) begin
                check({tag, "_mem_addr"}, bus.mem_addr, addr);
                check({tag, "_mem_len"}, 64'(bus.mem_len), 64'(size));
            end
            if (bus.resp_valid) begin
                lat = c;
                break;
            end
        end
        bus.req_valid = 1'b0;
        exp_lat = exp_err ? 1 : (we ? 3 : 2);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_we_cycles"}, 64'(we_c), 64'((we && !exp_err) ? 1 : 0));
        check({tag, "_re_cycles"}, 64'(re_c), 64'((!we && !exp_err) ? 1 : 0));
        check({tag, "_we_re_overlap"}, 64'(both), 64'd0);
    endtask

    // Compare the pending response, optionally stall resp_ready, then complete the handshake.
    task automatic recv(input int hold, input string tag);
        logic [64:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd0, 64'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check({tag, "_rdata"}, bus.resp_rdata, e[63:0]);
        check({tag, "_err"}, 64'(bus.resp_err), 64'(e[64]));
        bus.resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(bus.resp_valid), 64'd1);
            check({tag, "_hold_rdata"}, bus.resp_rdata, e[63:0]);
            check({tag, "_hold_req_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_req_ready"}, 64'(bus.req_ready), 64'd1);
        check({tag, "_post_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    endtask

    task automatic xfer(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic uns,
                        input logic [63:0] exp_rdata, input logic exp_err, input int hold, input string tag);
        send(we, addr, wdata, size, uns, exp_rdata, exp_err, tag);
        recv(hold, tag);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic        r_we, r_uns, r_err;
        logic [1:0]  r_size;
        logic [63:0] r_addr, r_wdata, r_exp;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_size = SZ_B; bus.req_unsigned = 1'b0; bus.resp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end

        #23;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        check("rst_mem_wdata", bus.mem_wdata, 64'd0);
        check("rst_mem_we_re", {62'd0, bus.mem_we, bus.mem_re}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_req_ready", 64'(bus.req_ready), 64'd1);

        // Doubleword store then load.
        xfer(1, 64'h40, 64'h1122334455667788, SZ_D, 0, 64'd0, 0, 0, "st_d");
        check("st_d_ram_lane0", 64'(ram[64]), 64'h88);
        check("st_d_ram_lane7", 64'(ram[71]), 64'h11);
        xfer(0, 64'h40, 64'd0, SZ_D, 0, 64'h1122334455667788, 0, 0, "ld_d");

        // Byte sign / zero extension.
        xfer(1, 64'h10, 64'h80, SZ_B, 0, 64'd0, 0, 0, "st_b");
        xfer(0, 64'h10, 64'd0, SZ_B, 0, 64'hFFFFFFFFFFFFFF80, 0, 0, "ld_b_s");
        xfer(0, 64'h10, 64'd0, SZ_B, 1, 64'h0000000000000080, 0, 0, "ld_b_u");

        // Word / half extension.
        xfer(1, 64'h20, 64'hDEAD_0000_89AB_CDEF, SZ_W, 0, 64'd0, 0, 0, "st_w");
        xfer(0, 64'h20, 64'd0, SZ_W, 0, 64'hFFFFFFFF89ABCDEF, 0, 0, "ld_w_s");
        xfer(0, 64'h20, 64'd0, SZ_W, 1, 64'h0000000089ABCDEF, 0, 0, "ld_w_u");
        xfer(0, 64'h20, 64'd0, SZ_H, 0, 64'hFFFFFFFFFFFFCDEF, 0, 0, "ld_h_s");
        xfer(0, 64'h24, 64'd0, SZ_W, 0, 64'd0, 0, 0, "ld_w_upper_clear");

        // Misalignment and range errors.
        xfer(0, 64'h102, 64'd0, SZ_W, 0, 64'd0, 1, 0, "ld_misaligned");
        xfer(1, 64'h3FF, 64'hBEEF, SZ_H, 0, 64'd0, 1, 0, "st_h_range");
        xfer(1, 64'h3FE, 64'hA55A, SZ_H, 0, 64'd0, 0, 0, "st_h_top");
        xfer(0, 64'h3FE, 64'd0, SZ_B, 1, 64'h5A, 0, 0, "ld_b_3fe");
        xfer(0, 64'h3FF, 64'd0, SZ_B, 1, 64'hA5, 0, 0, "ld_b_3ff");
        xfer(0, 64'h3FC, 64'd0, SZ_D, 0, 64'd0, 1, 0, "ld_d_range");
        xfer(0, 64'h400, 64'd0, SZ_B, 0, 64'd0, 1, 0, "ld_b_past_end");

        // Backpressure on the response.
        xfer(0, 64'h40, 64'd0, SZ_D, 0, 64'h1122334455667788, 0, 5, "ld_bp");

        // Reset during WRITE.
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_addr = 64'h80; bus.req_wdata = 64'hCAFEF00DCAFEF00D;
        bus.req_size = SZ_D; bus.req_unsigned = 1'b0; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("mid_rst_we_before", 64'(bus.mem_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 64'(bus.mem_we), 64'd0);
        check("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_release_ready", 64'(bus.req_ready), 64'd1);
        xfer(0, 64'h40, 64'd0, SZ_W, 1, 64'h0000000055667788, 0, 0, "ld_after_rst");

        // Random mix checked against the reference memory.
        for (int n = 0; n < 24; n++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_uns   = 1'($urandom_range(0, 1));
            r_addr  = 64'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~64'(nb(r_size) - 1);
            r_wdata = {$urandom, $urandom};
            r_err   = model_err(r_addr, r_size);
            r_exp   = (r_we || r_err) ? 64'd0 : model_load(r_addr, r_size, r_uns);
            xfer(r_we, r_addr, r_wdata, r_size, r_uns, r_exp, r_err, $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Initiator side of the byte-addressed data RAM port. It takes load/store requests from the core execute stage over a valid/ready handshake and drives the RAM data-port signals: address, write data, length, write enable and read enable. For loads it captures the RAM read data, extracts the requested size and sign- or zero-extends it. It returns one response per request. It also checks alignment and range, so an illegal access never reaches the RAM.

Parameters:
ALEN, 64, address width
DLEN, 64, data width (the data path is 8 byte lanes)
MEM_SIZE, 1024, RAM size in bytes; an access with addr+bytes > MEM_SIZE is an error
CHECK_ALIGN, 1, 1 = a misaligned access is an error; 0 = misaligned is allowed

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  a request is presented
req_ready  out  1  block can accept a request; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  ALEN  byte address
req_wdata  in  DLEN  store data, right-justified
req_size  in  2  access size: 00 = 1 byte, 01 = 2, 10 = 4, 11 = 8
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
resp_valid  out  1  a response is pending
resp_ready  in  1  consumer accepts the response
resp_rdata  out  DLEN  extended load data; 0 for stores and errors
resp_err  out  1  request was misaligned or out of range; no RAM access was made
mem_addr  out  ALEN  RAM byte address
mem_wdata  out  DLEN  RAM write bus, lane-first: bits [63-8k -: 8] are written to addr+k
mem_len  out  2  RAM length code, equal to req_size
mem_we  out  1  RAM write enable
mem_re  out  1  RAM read enable
mem_rdata  in  DLEN  RAM read bus: bits [8k+7:8k] = mem[addr+k]

Behaviour:
- Reset (asynchronous): state = IDLE; clear req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_len, mem_we and mem_re. req_ready rises on the first clock edge after rst_n is released.
- All mem_* outputs are registered. mem_addr, mem_wdata and mem_len change only on request acceptance, so they are stable for the whole time mem_we or mem_re is high. The RAM is level-sensitive, so this stability is mandatory.
- States: IDLE, READ, WRITE, WHOLD, RESP.
- IDLE: req_ready = 1. On req_valid & req_ready, latch the request and load mem_addr, mem_len and the packed mem_wdata.
  - Error request: go to RESP with resp_err = 1.
  - Load: go to READ.
  - Store: go to WRITE.
- Error condition: (CHECK_ALIGN && addr mod 2^size != 0) || (addr + 2^size > MEM_SIZE). Compute it at ALEN+1 bits so the sum cannot wrap.
- Store packing: byte k of req_wdata is placed on mem_wdata lane [63-8k -: 8]. Lanes at or above 2^size are driven 0.
- READ: mem_re = 1 for exactly one cycle. At the end of the cycle, capture the extended mem_rdata into resp_rdata. Next state RESP.
- Load extension: take the low 2^size bytes of mem_rdata. Sign-extend from bit 8·2^size−1 unless req_unsigned is set. Size 11 is passed through unchanged.
- WRITE: mem_we = 1 for exactly one cycle. Next state WHOLD.
- WHOLD: mem_we = 0; address and data are held. Next state RESP. This gives the latch-based write one full hold cycle.
- RESP: resp_valid = 1, and resp_rdata and resp_err are stable until resp_ready. On resp_valid & resp_ready, clear resp_valid and go to IDLE. A new request can be accepted on the following cycle; the block is non-pipelined with one outstanding request.
- Latency from the accept edge (cycle N) to resp_valid:
  - load: N+2
  - store: N+3
  - error: N+1
- mem_we and mem_re are never high in the same cycle, and are never high in IDLE or RESP.
- Reset mid-operation: mem_we and mem_re drop immediately, and any pending response is discarded. A store interrupted during WRITE may leave partial bytes in the RAM; this is permitted.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum lsu_state_t {IDLE, READ, WRITE, WHOLD, RESP}
  - size constants SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11
  - function size_bytes(size)
- One sub-module, lsu_load_extend: combinational extract and extend (inputs rdata, size, unsigned; output ext_data).

Test Plan:
- Store, then load: store D, addr 0x40, wdata 0x1122334455667788 → mem_wdata 0x8877665544332211, mem_we high for 1 cycle, resp at N+3 with err=0. Then load D from 0x40 → resp_rdata 0x1122334455667788 at N+2.
- Sign/zero extension: store B 0x80 at 0x10. Load B signed → 0xFFFFFFFFFFFFFF80. Load B unsigned → 0x0000000000000080.
- Misaligned: load W at 0x102 with CHECK_ALIGN=1 → resp_err=1 at N+1, resp_rdata=0, mem_re and mem_we never asserted.
- Range: store H at 0x3FF → err (0x3FF+2 > 1024). Store H at 0x3FE → ok, bytes land at 0x3FE and 0x3FF.
- Backpressure: hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stable, req_ready=0 throughout, accept on the first cycle after the handshake.
- Reset: drop rst_n during WRITE → mem_we=0 and resp_valid=0 immediately. After release, req_ready=1 on the next edge and a new load completes normally.
